// File: rtl/lc3_pkg.sv
// lc3_pkg: states, select encodings, opcodes and output decode for lc3_control.
// Build option PAUSE_IR_EN adds the PauseIR1/PauseIR2 fetch-debug states.
package lc3_pkg;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_18,
    ST_33,
    ST_35,
    ST_32,
    ST_1,
    ST_5,
    ST_9,
    ST_22,
    ST_12,
    ST_4,
    ST_21,
    ST_20,
    ST_6,
    ST_25,
    ST_27,
    ST_7,
    ST_23,
    ST_16,
`ifdef PAUSE_IR_EN
    ST_PAUSE_IR1,
    ST_PAUSE_IR2,
`endif
    ST_PAUSE_A,
    ST_PAUSE_B
  } state_t;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BUS  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       sr2mux;
    logic       addr1mux;
    logic       marmux;
    logic       drmux;
    logic       sr1mux;
    logic       mio_en;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  // Control word for a state; last marks the final memory-wait cycle.
  function automatic ctrl_t decode(
    input state_t s,
    input logic   last,
    input logic   ir_5
  );
    ctrl_t c;
    c = '0;
    unique case (s)
      ST_18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pcmux   = PC_INC;
        c.ld_pc   = 1'b1;
      end
      ST_33, ST_25: begin
        c.mem_oe = 1'b1;
        c.mio_en = 1'b1;
        c.ld_mdr = last;
      end
      ST_35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      ST_32: c.ld_ben = 1'b1;
      ST_1, ST_5: begin
        c.sr1mux   = 1'b1;
        c.sr2mux   = ir_5;
        c.aluk     = (s == ST_1) ? ALUK_ADD
                                 : ALUK_AND;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      ST_9: begin
        c.sr1mux   = 1'b1;
        c.aluk     = ALUK_NOT;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      ST_22: begin
        c.addr2mux = A2_OFF9;
        c.pcmux    = PC_ADDR;
        c.ld_pc    = 1'b1;
      end
      ST_12: begin
        c.sr1mux   = 1'b1;
        c.addr1mux = 1'b1;
        c.addr2mux = A2_ZERO;
        c.pcmux    = PC_ADDR;
        c.ld_pc    = 1'b1;
      end
      ST_4: begin
        c.gate_pc = 1'b1;
        c.drmux   = 1'b1;
        c.ld_reg  = 1'b1;
      end
      ST_21: begin
        c.addr2mux = A2_OFF11;
        c.pcmux    = PC_ADDR;
        c.ld_pc    = 1'b1;
      end
      ST_20: begin
        c.addr1mux = 1'b1;
        c.addr2mux = A2_ZERO;
        c.pcmux    = PC_ADDR;
        c.ld_pc    = 1'b1;
      end
      ST_6, ST_7: begin
        c.sr1mux      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = A2_OFF6;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      ST_27: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      ST_23: begin
        c.aluk     = ALUK_PASSA;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      ST_16: c.mem_we = 1'b1;
`ifdef PAUSE_IR_EN
      ST_PAUSE_IR1: c.ld_led = 1'b1;
`endif
      ST_PAUSE_A: c.ld_led = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc3_control_mem_wait_ctr.sv
// mem_wait_ctr: saturating 3-bit memory wait counter.
// done flags the last wait cycle; done_nxt flags it one cycle early.
module mem_wait_ctr
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done,
  output logic done_nxt
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] cnt;
  logic [2:0] cnt_n;

  // Clear wins; counting stops at LAST so it never wraps.
  always_comb begin
    cnt_n = cnt;
    if (clr)
      cnt_n = '0;
    else if (en && cnt != LAST)
      cnt_n = cnt + 3'd1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_n;
  end

  assign done     = (cnt == LAST);
  assign done_nxt = (cnt_n == LAST);

endmodule

// File: rtl/lc3_control.sv
// lc3_control: LC-3 fetch/decode/execute Moore FSM with registered outputs.
// Define PAUSE_IR_EN to single-step each fetch through PauseIR1/PauseIR2.
module lc3_control
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MARMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MIO_EN,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   done;
  logic   done_nxt;
  logic   is_wait;
  logic   clr;

  assign is_wait = (nxt inside {ST_33, ST_25, ST_16});
  assign clr     = !is_wait || (nxt != state);

  mem_wait_ctr #(
    .MEM_WAIT(MEM_WAIT)
  ) u_ctr (
    .clk     (Clk),
    .rst     (Reset),
    .clr     (clr),
    .en      (is_wait),
    .done    (done),
    .done_nxt(done_nxt)
  );

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_HALTED: if (Run) nxt = ST_18;
      ST_18:     nxt = ST_33;
      ST_33:     if (done) nxt = ST_35;
`ifdef PAUSE_IR_EN
      ST_35:     nxt = ST_PAUSE_IR1;
      ST_PAUSE_IR1:
        if (Continue) nxt = ST_PAUSE_IR2;
      ST_PAUSE_IR2:
        if (!Continue) nxt = ST_32;
`else
      ST_35:     nxt = ST_32;
`endif
      ST_32: begin
        nxt = ST_18;
        unique case (1'b1)
          Opcode == OP_ADD: nxt = ST_1;
          Opcode == OP_AND: nxt = ST_5;
          Opcode == OP_NOT: nxt = ST_9;
          Opcode == OP_BR:
            nxt = BEN ? ST_22 : ST_18;
          Opcode == OP_JMP: nxt = ST_12;
          Opcode == OP_JSR: nxt = ST_4;
          Opcode == OP_LDR: nxt = ST_6;
          Opcode == OP_STR: nxt = ST_7;
          Opcode == OP_PSE: nxt = ST_PAUSE_A;
          default:          nxt = ST_18;
        endcase
      end
      ST_4:  nxt = IR_11 ? ST_21 : ST_20;
      ST_6:  nxt = ST_25;
      ST_25: if (done) nxt = ST_27;
      ST_7:  nxt = ST_23;
      ST_23: nxt = ST_16;
      ST_16: if (done) nxt = ST_18;
      ST_PAUSE_A:
        if (Continue) nxt = ST_PAUSE_B;
      ST_PAUSE_B:
        if (!Continue) nxt = ST_18;
      ST_1, ST_5, ST_9, ST_22,
      ST_12, ST_21, ST_20, ST_27:
        nxt = ST_18;
      default: nxt = ST_HALTED;
    endcase
  end

  // State and control word registered together from the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_HALTED;
      ctrl  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt, done_nxt, IR_5);
    end
  end

  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_BEN     = ctrl.ld_ben;
  assign LD_CC      = ctrl.ld_cc;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_PC      = ctrl.ld_pc;
  assign LD_LED     = ctrl.ld_led;
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign SR2MUX     = ctrl.sr2mux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign MARMUX     = ctrl.marmux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign MIO_EN     = ctrl.mio_en;
  assign PCMUX      = ctrl.pcmux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign ALUK       = ctrl.aluk;
  assign Mem_OE     = ctrl.mem_oe;
  assign Mem_WE     = ctrl.mem_we;

endmodule

// File: tb/tb_lc3_control.sv
// tb_lc3_control: directed per-cycle vector table for lc3_control,
// plus async reset mid-pause and a random gate-exclusivity stream.
module tb_lc3_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Run;
  logic        Continue;
  logic        BEN;
  logic [15:0] ir;
  logic [3:0]  Opcode;
  logic        IR_5;
  logic        IR_11;

  logic LD_MAR, LD_MDR, LD_IR, LD_BEN;
  logic LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic SR2MUX, ADDR1MUX, MARMUX;
  logic DRMUX, SR1MUX, MIO_EN;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic Mem_OE, Mem_WE;

  assign Opcode = ir[15:12];
  assign IR_5   = ir[5];
  assign IR_11  = ir[11];

  lc3_control #(.MEM_WAIT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG),
    .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR),
    .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MARMUX(MARMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .MIO_EN(MIO_EN),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  logic [25:0] outv;
  assign outv = {LD_MAR, LD_MDR, LD_IR, LD_BEN,
                 LD_CC, LD_REG, LD_PC, LD_LED,
                 GatePC, GateMDR, GateALU, GateMARMUX,
                 SR2MUX, ADDR1MUX, MARMUX, DRMUX,
                 SR1MUX, MIO_EN, PCMUX, ADDR2MUX,
                 ALUK, Mem_OE, Mem_WE};

  localparam logic [25:0] WE    = 26'h0000001;
  localparam logic [25:0] OE    = 26'h0000002;
  localparam logic [25:0] K_AND = 26'h0000004;
  localparam logic [25:0] K_PA  = 26'h000000C;
  localparam logic [25:0] A2_6  = 26'h0000010;
  localparam logic [25:0] A2_9  = 26'h0000020;
  localparam logic [25:0] A2_11 = 26'h0000030;
  localparam logic [25:0] P_ADR = 26'h0000080;
  localparam logic [25:0] MIO   = 26'h0000100;
  localparam logic [25:0] SR1   = 26'h0000200;
  localparam logic [25:0] DR    = 26'h0000400;
  localparam logic [25:0] A1    = 26'h0001000;
  localparam logic [25:0] SR2   = 26'h0002000;
  localparam logic [25:0] G_MM  = 26'h0004000;
  localparam logic [25:0] G_ALU = 26'h0008000;
  localparam logic [25:0] G_MDR = 26'h0010000;
  localparam logic [25:0] G_PC  = 26'h0020000;
  localparam logic [25:0] LED   = 26'h0040000;
  localparam logic [25:0] L_PC  = 26'h0080000;
  localparam logic [25:0] L_REG = 26'h0100000;
  localparam logic [25:0] L_CC  = 26'h0200000;
  localparam logic [25:0] L_BEN = 26'h0400000;
  localparam logic [25:0] L_IR  = 26'h0800000;
  localparam logic [25:0] L_MDR = 26'h1000000;
  localparam logic [25:0] L_MAR = 26'h2000000;

  localparam logic [25:0] E18  = G_PC | L_MAR | L_PC;
  localparam logic [25:0] E33W = OE | MIO;
  localparam logic [25:0] E33L = OE | MIO | L_MDR;
  localparam logic [25:0] E35  = G_MDR | L_IR;
  localparam logic [25:0] E32  = L_BEN;
  localparam logic [25:0] EADD = SR1 | G_ALU | L_REG | L_CC;
  localparam logic [25:0] EANDI =
    SR1 | SR2 | K_AND | G_ALU | L_REG | L_CC;
  localparam logic [25:0] E22  = A2_9 | P_ADR | L_PC;
  localparam logic [25:0] E4   = G_PC | DR | L_REG;
  localparam logic [25:0] E21  = A2_11 | P_ADR | L_PC;
  localparam logic [25:0] EADR = SR1 | A1 | A2_6 | G_MM | L_MAR;
  localparam logic [25:0] E23  = K_PA | G_ALU | L_MDR;
  localparam logic [25:0] E27  = G_MDR | L_REG | L_CC;

  typedef struct {
    logic        rst;
    logic        run;
    logic        cont;
    logic        ben;
    logic [15:0] ir;
    logic [25:0] exp;
    string       name;
  } vec_t;

  vec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input logic rst, input logic run,
    input logic cont, input logic ben,
    input logic [15:0] i, input logic [25:0] e,
    input string n
  );
    vec_t v;
    v.rst = rst; v.run = run; v.cont = cont;
    v.ben = ben; v.ir = i; v.exp = e; v.name = n;
    q.push_back(v);
  endtask

  task automatic add_fetch(
    input logic [15:0] i, input logic ben
  );
    add(0, 0, 0, ben, i, E33W, "s33_wait");
    add(0, 0, 0, ben, i, E33L, "s33_mdr");
    add(0, 0, 0, ben, i, E35,  "s35");
    add(0, 0, 0, ben, i, E32,  "s32");
  endtask

  task automatic check(
    input string n, input logic [25:0] got,
    input logic [25:0] want
  );
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    BEN = 1'b0; ir = 16'h1042;

    add(1, 0, 0, 0, 16'h1042, '0,   "reset");
    add(0, 0, 0, 0, 16'h1042, '0,   "halted_idle");
    add(0, 1, 0, 0, 16'h1042, E18,  "run_s18");
    add(0, 1, 0, 0, 16'h1042, E33W, "s33_run_held");
    add(0, 0, 0, 0, 16'h1042, E33L, "s33_mdr");
    add(0, 0, 0, 0, 16'h1042, E35,  "s35");
    add(0, 0, 0, 0, 16'h1042, E32,  "s32");
    add(0, 0, 0, 0, 16'h1042, EADD, "add_exec");
    add(0, 0, 0, 1, 16'h0E05, E18,  "add_to_s18");
    add_fetch(16'h0E05, 1'b1);
    add(0, 0, 0, 1, 16'h0E05, E22,  "br_taken");
    add(0, 0, 0, 0, 16'h0E05, E18,  "br_to_s18");
    add_fetch(16'h0E05, 1'b0);
    add(0, 0, 0, 0, 16'h0E05, E18,  "br_not_taken");
    add_fetch(16'h4803, 1'b0);
    add(0, 0, 0, 0, 16'h4803, E4,   "jsr_s4");
    add(0, 0, 0, 0, 16'h4803, E21,  "jsr_off11");
    add(0, 0, 0, 0, 16'h4803, E18,  "jsr_to_s18");
    add_fetch(16'h7042, 1'b0);
    add(0, 0, 0, 0, 16'h7042, EADR, "str_addr");
    add(0, 0, 0, 0, 16'h7042, E23,  "str_s23");
    add(0, 0, 0, 0, 16'h7042, WE,   "str_we1");
    add(0, 0, 0, 0, 16'h7042, WE,   "str_we2");
    add(0, 0, 0, 0, 16'h7042, E18,  "str_to_s18");
    add_fetch(16'hD00F, 1'b0);
    add(0, 0, 0, 0, 16'hD00F, LED,  "pause_a");
    add(0, 0, 0, 0, 16'hD00F, LED,  "pause_a_hold");
    for (int k = 0; k < 5; k++)
      add(0, 0, 1, 0, 16'hD00F, '0, "pause_b_hold");
    add(0, 0, 0, 0, 16'hD00F, E18,  "pause_release");
    add_fetch(16'h6042, 1'b0);
    add(0, 0, 0, 0, 16'h6042, EADR, "ldr_addr");
    add(0, 0, 0, 0, 16'h6042, E33W, "ldr_s25_wait");
    add(0, 0, 0, 0, 16'h6042, E33L, "ldr_s25_mdr");
    add(0, 0, 0, 0, 16'h6042, E27,  "ldr_s27");
    add(0, 0, 0, 0, 16'h6042, E18,  "ldr_to_s18");
    add_fetch(16'h5021, 1'b0);
    add(0, 0, 0, 0, 16'h5021, EANDI, "and_imm");
    add(0, 0, 0, 0, 16'h5021, E18,  "and_to_s18");
    add_fetch(16'h8000, 1'b0);
    add(0, 0, 0, 0, 16'h8000, E18,  "unknown_op");

    foreach (q[k]) begin
      Reset    = q[k].rst;
      Run      = q[k].run;
      Continue = q[k].cont;
      BEN      = q[k].ben;
      ir       = q[k].ir;
      step();
      check(q[k].name, outv, q[k].exp);
    end

    // Reset arriving mid-pause clears outputs without a clock edge.
    ir = 16'hD00F; Continue = 1'b0;
    repeat (4) step();
    step();
    check("pause_led", outv, LED);
    #2;
    Reset = 1'b1;
    #1;
    check("reset_async", outv, '0);
    step();
    Reset = 1'b0;
    step();
    check("halted_after_reset", outv, '0);
    Run = 1'b1;
    step();
    check("restart_s18", outv, E18);
    Run = 1'b0;

    // Random instruction stream: at most one bus driver per cycle.
    begin
      int instr = 0;
      int cyc   = 0;
      while (instr < 500 && cyc < 20000) begin
        Continue = 1'($urandom_range(0, 1));
        BEN      = 1'($urandom_range(0, 1));
        ir       = 16'($urandom);
        step();
        cyc++;
        n_cmp++;
        if ($countones({GatePC, GateMDR,
                        GateALU, GateMARMUX}) > 1) begin
          n_bad++;
          $display("FAIL gate_excl: got %b want <=1 high",
                   {GatePC, GateMDR, GateALU, GateMARMUX});
        end
        if (LD_IR) instr++;
      end
      n_cmp++;
      if (instr < 500) begin
        n_bad++;
        $display("FAIL rand_budget: got %0d instr want 500",
                 instr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_control.md
Name: lc3_control

Overview:
- Moore FSM that sequences the LC-3 datapath through fetch, decode and execute.
- Drives every load, gate and mux select into the datapath, plus memory OE/WE.
- Takes opcode/IR bits and BEN back from the datapath, and Run/Continue from board switches.
- Sits beside the datapath inside the top-level SLC-3 wrapper.

Parameters:
- MEM_WAIT, 2: memory access cycles (1..7) with Mem_OE or Mem_WE held before data is valid or written.

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high; forces Halted
- Run  input  1  level; leave Halted and begin fetch
- Continue  input  1  level; release from PAUSE/debug-pause states
- Opcode  input  4  IR[15:12]
- IR_5  input  1  IR[5], immediate select for ADD/AND
- IR_11  input  1  IR[11], JSR vs JSRR
- BEN  input  1  branch-enable from condition-code unit
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle
- SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN  output  1 each  mux selects
- PCMUX, ADDR2MUX, ALUK  output  2 each  mux/ALU selects
- Mem_OE, Mem_WE  output  1 each  active-high memory read/write strobes

Behaviour:
- Reset (async): state = Halted, wait counter = 0, all outputs 0. Reset mid-instruction abandons it; no loads are asserted in the reset cycle.
- Every output defaults to 0 in every state; each state raises only what it lists.
- Encodings:
  - ALUK: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
  - PCMUX: 00 PC+1, 01 BUS, 10 address adder.
  - ADDR2MUX: 00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0]).
  - ADDR1MUX: 0 PC, 1 SR1.
  - SR1MUX: 0 IR[11:9], 1 IR[8:6].
  - DRMUX: 0 IR[11:9], 1 R7.
  - SR2MUX: 1 imm5.
  - MIO_EN: 1 memory data into MDR.
- Halted: idle; Run=1 goes to S18.
- Fetch sequence:
  - S18: GatePC, LD_MAR, PCMUX=00, LD_PC.
  - S33: Mem_OE, MIO_EN. The wait counter counts 0..MEM_WAIT-1. LD_MDR is asserted only when the counter = MEM_WAIT-1, then go to S35 and clear the counter.
  - S35: GateMDR, LD_IR, then S32.
- S32 (decode): LD_BEN, then branch on Opcode.
- ADD(0001) / AND(0101): SR1MUX=1, SR2MUX=IR_5, ALUK=00 or 01, GateALU, DRMUX=0, LD_REG, LD_CC, then S18.
- NOT(1001): SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC, then S18.
- BR(0000): if BEN, S22 (ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC). Else S18.
- JMP(1100): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
- JSR(0100):
  - S4: GatePC, DRMUX=1, LD_REG.
  - Then IR_11=1: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC.
  - IR_11=0: ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC.
- LDR(0110): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR; then S25 memory wait (same counter rule as S33); then S27: GateMDR, DRMUX=0, LD_REG, LD_CC.
- STR(0111):
  - SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR.
  - S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR.
  - S16: Mem_WE held MEM_WAIT cycles, then S18.
- PAUSE(1101): PauseA asserts LD_LED. Stays while Continue=0; Continue=1 goes to PauseB. PauseB stays while Continue=1, then S18. One press = one release.
- Any other opcode: S32 goes to S18 with no side effects.
- Run level is ignored outside Halted. Only Reset returns to Halted.
- Wait counter width is 3 bits. It is cleared on every entry to a wait state and never wraps inside a state.

Optional Feature:
- PAUSE_IR_EN defined: S35 goes to PauseIR1 (LD_LED). Wait for Continue=1, then PauseIR2; wait for Continue=0, then S32. This single-steps fetch for board debug.
- Undefined: S35 goes directly to S32; the PauseIR states are not compiled.

Decomposition:
- Package lc3_pkg holds:
  - state enum (state_t);
  - ALUK, PCMUX and ADDR2MUX encodings as localparams;
  - opcode constants (OP_ADD .. OP_PSE).
- One sub-module, mem_wait_ctr: 3-bit counter with clear/enable and a done flag. It is shared by S33, S25 and S16.

Test Plan:
- Reset, then Run=1 with IR=0x1042 (ADD R0,R1,R2), MEM_WAIT=2: S18→S33×2→S35→S32→ADD.
  - LD_MDR high only in the 2nd S33 cycle.
  - ADD cycle has GateALU=1, ALUK=00, SR2MUX=0, LD_REG=LD_CC=1, and all other gates 0.
- IR=0x0E05 (BRnzp) with BEN=1: S22 asserts PCMUX=10, ADDR2MUX=10, LD_PC. With BEN=0: S32 returns to S18 with LD_PC=0.
- IR=0x4803 (JSR): S4 asserts GatePC, DRMUX=1, LD_REG. The next state asserts ADDR2MUX=11, PCMUX=10.
- IR=0x7042 (STR): Mem_WE high for exactly 2 cycles, Mem_OE=0 throughout, MIO_EN=0 during LD_MDR.
- IR=0xD00F (PAUSE): LD_LED asserted. Holding Continue=1 for 5 cycles stays in PauseB; dropping it gives S18 next cycle. Reset asserted mid-pause: outputs 0 immediately and state Halted.
- Gate exclusivity assertion: the sum of gate outputs is ≤1 on every cycle across a random opcode stream of 500 instructions.
